// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic tiles.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit counter only needs to reach WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor_1bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, valid/ready on both sides.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_zero,
    output logic             ser_bit,
    output logic             ser_valid
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             fin_borrow_q, fin_borrow_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_bit, bout_bit;

    full_subtractor_1bit u_fs (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (borrow_q),
        .d_o    (d_bit),
        .bout_o (bout_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            fin_borrow_q <= 1'b0;
            zero_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            fin_borrow_q <= fin_borrow_d;
            zero_q       <= zero_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        fin_borrow_d = fin_borrow_q;
        zero_d       = zero_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                res_d    = {d_bit, res_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = bout_bit;
                if (cnt_q == LAST) begin
                    // Publish the completed result in the same edge as the last bit.
                    diff_d       = {d_bit, res_q[WIDTH-1:1]};
                    fin_borrow_d = bout_bit;
                    zero_d       = ({d_bit, res_q[WIDTH-1:1]} == '0);
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign ser_valid  = (state_q == SHIFT);
    assign ser_bit    = (state_q == SHIFT) & d_bit;
    assign out_diff   = diff_q;
    assign out_borrow = fin_borrow_q;
    assign out_zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 directed/random ops and an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_valid;
    logic [1:0] out_ready;
    logic [7:0] in_a [2];
    logic [7:0] in_b [2];
    wire  [1:0] in_ready, out_valid, out_borrow, out_zero, ser_bit, ser_valid;
    wire  [7:0] diff8;
    wire  [3:0] diff4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_diff(diff8), .out_borrow(out_borrow[0]), .out_zero(out_zero[0]),
        .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0])
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1][3:0]), .in_b(in_b[1][3:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_diff(diff4), .out_borrow(out_borrow[1]), .out_zero(out_zero[1]),
        .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1])
    );

    function automatic logic [7:0] get_diff(input int u);
        return (u == 1) ? {4'b0, diff4} : diff8;
    endfunction

    // One full operation on instance u of width w, checked against plain arithmetic.
    task automatic run_op(input int u, input int w, input logic [7:0] a_in, input logic [7:0] b_in,
                          input int stall, input bit junk);
        logic [7:0] mask, a, b, exp_d;
        logic       exp_b, exp_z;
        int         guard;
        mask  = 8'((1 << w) - 1);
        a     = a_in & mask;
        b     = b_in & mask;
        exp_d = 8'(a - b) & mask;
        exp_b = (a < b);
        exp_z = (exp_d == 8'd0);
        guard = 0;
        while (!in_ready[u] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_fail++;
            $display("FAIL wait_in_ready u=%0d: in_ready=%b required 1", u, in_ready[u]);
        end
        in_valid[u] = 1'b1;
        in_a[u]     = a;
        in_b[u]     = b;
        @(negedge clk);
        for (int k = 0; k < w; k++) begin
            if (junk) begin
                in_a[u] = 8'($urandom);
                in_b[u] = 8'($urandom);
            end else begin
                in_valid[u] = 1'b0;
            end
            n_cmp++;
            if (ser_valid[u] !== 1'b1 || ser_bit[u] !== exp_d[k] || in_ready[u] !== 1'b0 ||
                out_valid[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL shift_bit u=%0d a=%h b=%h k=%0d: sv=%b sb=%b ir=%b ov=%b required 1 %b 0 0",
                         u, a, b, k, ser_valid[u], ser_bit[u], in_ready[u], out_valid[u], exp_d[k]);
            end
            @(negedge clk);
        end
        in_valid[u] = 1'b0;
        n_cmp++;
        if (out_valid[u] !== 1'b1 || get_diff(u) !== exp_d || out_borrow[u] !== exp_b ||
            out_zero[u] !== exp_z || ser_valid[u] !== 1'b0) begin
            n_fail++;
            $display("FAIL result u=%0d a=%h b=%h: ov=%b diff=%h bor=%b z=%b sv=%b required 1 %h %b %b 0",
                     u, a, b, out_valid[u], get_diff(u), out_borrow[u], out_zero[u], ser_valid[u],
                     exp_d, exp_b, exp_z);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid[u] !== 1'b1 || get_diff(u) !== exp_d || out_borrow[u] !== exp_b ||
                out_zero[u] !== exp_z || in_ready[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL hold u=%0d s=%0d: ov=%b diff=%h bor=%b z=%b ir=%b required 1 %h %b %b 0",
                         u, s, out_valid[u], get_diff(u), out_borrow[u], out_zero[u], in_ready[u],
                         exp_d, exp_b, exp_z);
            end
        end
        out_ready[u] = 1'b1;
        @(negedge clk);
        out_ready[u] = 1'b0;
        n_cmp++;
        if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1 || get_diff(u) !== exp_d ||
            out_borrow[u] !== exp_b) begin
            n_fail++;
            $display("FAIL release u=%0d: ov=%b ir=%b diff=%h bor=%b required 0 1 %h %b",
                     u, out_valid[u], in_ready[u], get_diff(u), out_borrow[u], exp_d, exp_b);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || get_diff(u) !== 8'd0 ||
                out_borrow[u] !== 1'b0 || out_zero[u] !== 1'b0 || ser_valid[u] !== 1'b0 ||
                ser_bit[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s u=%0d: ir=%b ov=%b diff=%h bor=%b z=%b sv=%b sb=%b required 1 0 00 0 0 0 0",
                         tag, u, in_ready[u], out_valid[u], get_diff(u), out_borrow[u], out_zero[u],
                         ser_valid[u], ser_bit[u]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");
    endtask

    task automatic test_directed();
        run_op(0, 8, 8'h5A, 8'h23, 0, 1'b0);
        run_op(0, 8, 8'h00, 8'h01, 0, 1'b0);
        run_op(0, 8, 8'h80, 8'h80, 0, 1'b0);
        run_op(0, 8, 8'hFF, 8'h00, 1, 1'b0);
        run_op(0, 8, 8'h00, 8'hFF, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(0, 8, 8'h3C, 8'hC3, 5, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_op(0, 8, 8'h91, 8'h17, 0, 1'b1);
        run_op(0, 8, 8'h17, 8'h91, 2, 1'b0);
    endtask

    task automatic test_reset_midshift();
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_a[0]     = 8'hFF;
        in_b[0]     = 8'h0F;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_midshift");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL no_pulse c=%0d: ov=%b ir=%b required 0 1", c, out_valid[0], in_ready[0]);
            end
        end
        run_op(0, 8, 8'hFF, 8'h0F, 0, 1'b0);
    endtask

    task automatic test_random8();
        for (int i = 0; i < 20; i++) begin
            run_op(0, 8, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    task automatic test_exhaustive4();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(1, 4, 8'(a), 8'(b), int'($urandom_range(0, 2)), 1'b0);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_a[0] = '0; in_a[1] = '0;
        in_b[0] = '0; in_b[1] = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_busy_ignore();
        test_reset_midshift();
        test_random8();
        test_exhaustive4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
